// File: rtl/tenthirty_ctrl.sv
// Ten-and-a-half round sequencer: drives deck draws, scores both hands,
// applies bust/stand/five-card rules and tracks deck depletion.
module tenthirty_ctrl #(
  parameter int DEALER_STAND = 14,
  parameter int MAX_CARDS    = 5,
  parameter int DECK_SIZE    = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic [3:0] number,
  output logic       pip,
  output logic [5:0] player_pts,
  output logic [5:0] dealer_pts,
  output logic [2:0] player_cnt,
  output logic [2:0] dealer_cnt,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic       lose,
  output logic       tie,
  output logic       deck_empty
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PDRAW = 3'd1;
  localparam logic [2:0] S_PWAIT = 3'd2;
  localparam logic [2:0] S_PDEC  = 3'd3;
  localparam logic [2:0] S_DDRAW = 3'd4;
  localparam logic [2:0] S_DWAIT = 3'd5;
  localparam logic [2:0] S_DDEC  = 3'd6;
  localparam logic [2:0] S_RES   = 3'd7;

  localparam logic [5:0] STAND_PTS = 6'(DEALER_STAND);
  localparam logic [2:0] MAXC      = 3'(MAX_CARDS);
  localparam logic [5:0] DECKN     = 6'(DECK_SIZE);
  localparam logic [5:0] BUST_LIM  = 6'd21;

  logic [2:0] state_q, state_d;
  logic       pip_q, pip_d;
  logic [5:0] ppts_q, ppts_d;
  logic [5:0] dpts_q, dpts_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic       tie_q, tie_d;
  logic       empty_q, empty_d;
  logic [5:0] drawn_q, drawn_d;
  logic       no_cards;

  function automatic logic [5:0] card_val(input logic [3:0] n);
    logic [5:0] v;
    v = 6'd0;
    unique case (1'b1)
      (n >= 4'd1 && n <= 4'd10):  v = {1'b0, n, 1'b0};
      (n >= 4'd11 && n <= 4'd13): v = 6'd1;
      default:                    v = 6'd0;
    endcase
    return v;
  endfunction

  // The pip is raised on entry to a draw state; a draw with no cards
  // left enters the draw state with pip low and then voids the round.
  assign no_cards = (drawn_q >= DECKN);

  // Next-state and next-output logic for the round sequencer.
  always_comb begin
    state_d = state_q;
    pip_d   = 1'b0;
    ppts_d  = ppts_q;
    dpts_d  = dpts_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    win_d   = win_q;
    lose_d  = lose_q;
    tie_d   = tie_q;
    unique case (state_q)
      S_IDLE, S_RES: begin
        if (start) begin
          ppts_d  = 6'd0;
          dpts_d  = 6'd0;
          pcnt_d  = 3'd0;
          dcnt_d  = 3'd0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          tie_d   = 1'b0;
          state_d = S_PDRAW;
          pip_d   = !no_cards;
        end
      end
      S_PDRAW: state_d = pip_q ? S_PWAIT : S_RES;
      S_PWAIT: begin
        ppts_d  = ppts_q + card_val(number);
        pcnt_d  = pcnt_q + 3'd1;
        state_d = S_PDEC;
      end
      S_PDEC: begin
        if (ppts_q > BUST_LIM) begin
          lose_d  = 1'b1;
          state_d = S_RES;
        end else if (pcnt_q == MAXC) begin
          win_d   = 1'b1;
          state_d = S_RES;
        end else if (stand) begin
          state_d = S_DDRAW;
          pip_d   = !no_cards;
        end else if (hit) begin
          state_d = S_PDRAW;
          pip_d   = !no_cards;
        end
      end
      S_DDRAW: state_d = pip_q ? S_DWAIT : S_RES;
      S_DWAIT: begin
        dpts_d  = dpts_q + card_val(number);
        dcnt_d  = dcnt_q + 3'd1;
        state_d = S_DDEC;
      end
      S_DDEC: begin
        if (dpts_q > BUST_LIM) begin
          win_d   = 1'b1;
          state_d = S_RES;
        end else if (dpts_q >= STAND_PTS || dcnt_q == MAXC) begin
          win_d   = (ppts_q > dpts_q);
          lose_d  = (ppts_q < dpts_q);
          tie_d   = (ppts_q == dpts_q);
          state_d = S_RES;
        end else begin
          state_d = S_DDRAW;
          pip_d   = !no_cards;
        end
      end
      default: state_d = S_IDLE;
    endcase
    drawn_d = pip_d ? drawn_q + 6'd1 : drawn_q;
    empty_d = empty_q | no_cards;
    done_d  = (state_d == S_RES) && (state_q != S_RES);
    busy_d  = !(state_d == S_IDLE || state_d == S_RES);
  end

  // State and registered outputs; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pip_q   <= 1'b0;
      ppts_q  <= 6'd0;
      dpts_q  <= 6'd0;
      pcnt_q  <= 3'd0;
      dcnt_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      tie_q   <= 1'b0;
      empty_q <= 1'b0;
      drawn_q <= 6'd0;
    end else begin
      state_q <= state_d;
      pip_q   <= pip_d;
      ppts_q  <= ppts_d;
      dpts_q  <= dpts_d;
      pcnt_q  <= pcnt_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      tie_q   <= tie_d;
      empty_q <= empty_d;
      drawn_q <= drawn_d;
    end
  end

  assign pip        = pip_q;
  assign player_pts = ppts_q;
  assign dealer_pts = dpts_q;
  assign player_cnt = pcnt_q;
  assign dealer_cnt = dcnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign tie        = tie_q;
  assign deck_empty = empty_q;

endmodule

// File: tb/tb_tenthirty_ctrl.sv
// Bench for tenthirty_ctrl: deck LUT model, result scoreboard,
// vector table plus latency, reset and deck-depletion sequences.
module tb_tenthirty_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic [3:0] number;
  logic       pip, busy, done, win, lose, tie, deck_empty;
  logic [5:0] player_pts, dealer_pts;
  logic [2:0] player_cnt, dealer_cnt;

  always #5 clk = ~clk;

  tenthirty_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .stand(stand),
    .number(number), .pip(pip), .player_pts(player_pts),
    .dealer_pts(dealer_pts), .player_cnt(player_cnt),
    .dealer_cnt(dealer_cnt), .busy(busy), .done(done), .win(win),
    .lose(lose), .tie(tie), .deck_empty(deck_empty)
  );

  // Deck LUT model: registered card, pointer shares rst.
  logic [3:0] mem [64];
  int ptr = 0;
  int pip_total = 0;
  always @(posedge clk) begin
    if (rst) begin
      ptr    <= 0;
      number <= 4'd0;
    end else if (pip) begin
      number <= mem[ptr % 64];
      ptr    <= ptr + 1;
    end
    if (pip) pip_total <= pip_total + 1;
  end

  typedef struct {
    logic w, l, t;
    logic [5:0] pp, dp;
    logic [2:0] pc, dc;
  } exp_t;

  typedef struct {
    logic [31:0] deck;
    int nhits;
    bit both;
    exp_t e;
    int npips;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int dones = 0;
  logic done_prev = 1'b0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic exp_t mke(bit w, bit l, bit t, int pp, int dp,
                               int pc, int dc);
    exp_t e;
    e.w = w; e.l = l; e.t = t;
    e.pp = 6'(pp); e.dp = 6'(dp);
    e.pc = 3'(pc); e.dc = 3'(dc);
    return e;
  endfunction

  function automatic vec_t mkv(logic [31:0] deck, int nh, bit both,
                               exp_t e, int np);
    vec_t v;
    v.deck = deck; v.nhits = nh; v.both = both;
    v.e = e; v.npips = np;
    return v;
  endfunction

  // Scoreboard: each done pulse pops and checks one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      dones++;
      check("done_width", int'(done_prev), 0);
      check("busy_at_done", int'(busy), 0);
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("win", int'(win), int'(mon_e.w));
        check("lose", int'(lose), int'(mon_e.l));
        check("tie", int'(tie), int'(mon_e.t));
        check("player_pts", int'(player_pts), int'(mon_e.pp));
        check("dealer_pts", int'(dealer_pts), int'(mon_e.dp));
        check("player_cnt", int'(player_cnt), int'(mon_e.pc));
        check("dealer_cnt", int'(dealer_cnt), int'(mon_e.dc));
      end
    end
    done_prev = done;
  end

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic load_deck(logic [31:0] d);
    for (int i = 0; i < 64; i++)
      mem[i] = (i < 8) ? d[4*i +: 4] : 4'd0;
  endtask

  task automatic check_zero(string name);
    check(name, int'({pip, player_pts, dealer_pts, player_cnt,
                      dealer_cnt, busy, done, win, lose, tie,
                      deck_empty}), 0);
  endtask

  task automatic wait_done(int d0);
    int t;
    t = 0;
    while (dones == d0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (dones == d0) fail_now("wait_done");
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic play(vec_t v, bit do_rst);
    int d0, p0, t;
    if (do_rst) begin
      load_deck(v.deck);
      do_reset();
    end
    sbq.push_back(v.e);
    d0 = dones;
    p0 = pip_total;
    pulse_start();
    for (int k = 1; k <= v.nhits + 1; k++) begin
      t = 0;
      while (int'(player_cnt) < k && dones == d0 && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (dones != d0) break;
      if (t >= 60) begin
        fail_now("wait_player_dec");
        break;
      end
      if (k <= v.nhits) hit = 1'b1;
      else begin
        stand = 1'b1;
        if (v.both) hit = 1'b1;
      end
      @(negedge clk);
      hit = 1'b0;
      stand = 1'b0;
    end
    wait_done(d0);
    check("pip_count", pip_total - p0, v.npips);
  endtask

  vec_t vt[10];
  vec_t vbust;
  int d0, p0, t;

  initial begin
    vt[0] = mkv(32'h0000_08DA, 0, 0, mke(1,0,0,20,17,1,2), 3);
    vt[1] = mkv(32'h0000_00AA, 1, 0, mke(0,1,0,40, 0,2,0), 2);
    vt[2] = mkv(32'h0001_1111, 4, 0, mke(1,0,0,10, 0,5,0), 5);
    vt[3] = mkv(32'h0000_00AA, 0, 0, mke(0,0,1,20,20,1,1), 2);
    vt[4] = mkv(32'h0000_0563, 0, 0, mke(1,0,0, 6,22,1,2), 3);
    vt[5] = mkv(32'h0000_0092, 0, 0, mke(0,1,0, 4,18,1,1), 2);
    vt[6] = mkv(32'h0B0E_FDCB, 1, 0, mke(0,0,1, 2, 2,2,5), 7);
    vt[7] = mkv(32'h0000_07BA, 1, 0, mke(1,0,0,21,14,2,1), 3);
    vt[8] = mkv(32'h0000_00AA, 0, 1, mke(0,0,1,20,20,1,1), 2);
    vt[9] = mkv(32'h0000_001A, 1, 0, mke(0,1,0,22, 0,2,0), 2);
    vbust = mkv(32'h0, 1, 0, mke(0,1,0,40,0,2,0), 2);

    // Reset state and ignored buttons in IDLE.
    load_deck(32'h0000_08DA);
    do_reset();
    check_zero("reset_outputs");
    @(negedge clk) begin hit = 1'b1; stand = 1'b1; end
    @(negedge clk) begin hit = 1'b0; stand = 1'b0; end
    check_zero("idle_ignores_buttons");

    // Latency: start->pip, pip->pts two edges, stray start ignored.
    sbq.push_back(mke(1,0,0,20,17,1,2));
    d0 = dones;
    p0 = pip_total;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("pip_after_start", int'(pip), 1);
    check("busy_after_start", int'(busy), 1);
    @(negedge clk) start = 1'b1;
    check("pip_one_cycle", int'(pip), 0);
    check("pts_not_yet", int'(player_pts), 0);
    @(negedge clk) start = 1'b0;
    check("pts_updated", int'(player_pts), 20);
    check("cnt_updated", int'(player_cnt), 1);
    stand = 1'b1;
    @(negedge clk) stand = 1'b0;
    wait_done(d0);
    check("latency_pips", pip_total - p0, 3);

    // Table of rounds, each from a fresh reset.
    for (int i = 0; i < 10; i++) play(vt[i], 1'b1);

    // Reset mid-round during P_WAIT, then replay from card 0.
    load_deck(32'h0000_0075);
    do_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_zero("mid_round_reset");
    play(mkv(32'h0000_0075, 0, 0, mke(0,1,0,10,14,1,1), 2), 1'b0);

    // Deck depletion across 26 two-card rounds.
    for (int i = 0; i < 64; i++) mem[i] = 4'd10;
    do_reset();
    for (int r = 0; r < 25; r++) play(vbust, 1'b0);
    check("empty_at_50", int'(deck_empty), 0);
    sbq.push_back(vbust.e);
    d0 = dones;
    pulse_start();
    t = 0;
    while (player_cnt != 3'd1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) fail_now("wait_card1");
    hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    check("last_pip", int'(pip), 1);
    check("empty_on_last_pip", int'(deck_empty), 0);
    @(negedge clk);
    check("empty_after_last_pip", int'(deck_empty), 1);
    wait_done(d0);
    sbq.push_back(mke(0,0,0,0,0,0,0));
    d0 = dones;
    p0 = pip_total;
    pulse_start();
    wait_done(d0);
    check("void_no_pip", pip_total - p0, 0);
    check("empty_sticky", int'(deck_empty), 1);
    do_reset();
    check("empty_cleared", int'(deck_empty), 0);
    check("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
